// File: rtl/counter_johnson_decoder.sv
`default_nettype none
// ============================================================================
// Module      : counter_johnson_decoder
// Description : Decodes a sampled Johnson-code stream to a binary index, checks
//               legality and step order, runs a lock FSM and keeps error status.
// Revision    : 1.0 - initial release
// ============================================================================
module counter_johnson_decoder #(
    parameter int WIDTH      = 4,
    parameter int LOCK_CNT   = 3,
    parameter int ALLOW_HOLD = 1,
    parameter int ERR_CW     = 8
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_valid,
    input  logic [WIDTH-1:0]           i_johnson,
    input  logic                       i_clr_err,
    output logic [$clog2(2*WIDTH)-1:0] o_count,
    output logic                       o_count_valid,
    output logic                       o_illegal,
    output logic                       o_skip,
    output logic                       o_wrap,
    output logic                       o_locked,
    output logic                       o_err_sticky,
    output logic [ERR_CW-1:0]          o_err_cnt
);

    localparam int c_CW = $clog2(2*WIDTH);
    localparam int c_GW = $clog2(LOCK_CNT+1);
    localparam logic [c_CW-1:0] c_LAST      = c_CW'(2*WIDTH-1);
    localparam logic [c_GW-1:0] c_LOCK_LAST = c_GW'(LOCK_CNT-1);

    typedef enum logic [1:0] {
        S_SEARCH  = 2'd0,
        S_ACQUIRE = 2'd1,
        S_LOCKED  = 2'd2
    } state_t;

    state_t            r_state;
    logic              r_smp_valid;
    logic              r_smp_clr;
    logic [WIDTH-1:0]  r_smp_code;
    logic [c_CW-1:0]   r_prev;
    logic [c_GW-1:0]   r_good;
    logic [c_CW-1:0]   r_count;
    logic              r_count_valid;
    logic              r_illegal;
    logic              r_skip;
    logic              r_wrap;
    logic              r_err_sticky;
    logic [ERR_CW-1:0] r_err_cnt;

    logic [c_CW-1:0]   w_ones;
    logic [c_CW-1:0]   w_ntrans;
    logic [c_CW-1:0]   w_idx;
    logic [c_CW-1:0]   w_next;
    logic              w_legal;
    logic              w_step;
    logic              w_inorder;
    logic              w_wrap;
    logic              w_err_evt;
    logic [ERR_CW-1:0] w_err_base;
    logic [ERR_CW-1:0] w_err_nxt;
    logic              w_sticky_nxt;

    // Input capture: the clear travels with the sample it was presented with.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_smp_valid <= 1'b0;
            r_smp_clr   <= 1'b0;
            r_smp_code  <= '0;
        end else begin
            r_smp_valid <= i_valid;
            r_smp_clr   <= i_clr_err;
            r_smp_code  <= i_johnson;
        end
    end

    always_comb begin
        w_ones   = '0;
        w_ntrans = '0;
        for (int b = 0; b < WIDTH; b++) begin
            w_ones = w_ones + c_CW'(r_smp_code[b]);
        end
        for (int b = 0; b < WIDTH-1; b++) begin
            w_ntrans = w_ntrans + c_CW'(r_smp_code[b+1] ^ r_smp_code[b]);
        end
        w_legal   = (w_ntrans <= c_CW'(1));
        w_idx     = r_smp_code[WIDTH-1] ? (c_CW'(WIDTH) + (c_CW'(WIDTH) - w_ones)) : w_ones;
        w_next    = (r_prev == c_LAST) ? '0 : (r_prev + c_CW'(1));
        w_step    = (w_idx == w_next);
        w_inorder = w_step || ((ALLOW_HOLD != 0) && (w_idx == r_prev));
        w_wrap    = w_step && (r_prev == c_LAST);
        w_err_evt = r_smp_valid && (r_state == S_LOCKED) && (!w_legal || !w_inorder);
        // Clear is applied before the increment of a coincident error.
        w_err_base   = r_smp_clr ? '0 : r_err_cnt;
        w_err_nxt    = (w_err_evt && !(&w_err_base)) ? (w_err_base + ERR_CW'(1)) : w_err_base;
        w_sticky_nxt = w_err_evt || (r_err_sticky && !r_smp_clr);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= S_SEARCH;
            r_prev        <= '0;
            r_good        <= '0;
            r_count       <= '0;
            r_count_valid <= 1'b0;
            r_illegal     <= 1'b0;
            r_skip        <= 1'b0;
            r_wrap        <= 1'b0;
            r_err_sticky  <= 1'b0;
            r_err_cnt     <= '0;
        end else begin
            r_count_valid <= 1'b0;
            r_illegal     <= 1'b0;
            r_skip        <= 1'b0;
            r_wrap        <= 1'b0;
            r_err_sticky  <= w_sticky_nxt;
            r_err_cnt     <= w_err_nxt;
            if (r_smp_valid) begin
                if (!w_legal) begin
                    r_illegal <= 1'b1;
                    r_state   <= S_SEARCH;
                end else begin
                    r_count       <= w_idx;
                    r_count_valid <= 1'b1;
                    r_prev        <= w_idx;
                    case (r_state)
                        S_SEARCH: begin
                            r_good  <= '0;
                            r_state <= S_ACQUIRE;
                        end
                        S_ACQUIRE: begin
                            if (w_inorder) begin
                                r_wrap <= w_wrap;
                                if (r_good == c_LOCK_LAST) begin
                                    r_good  <= '0;
                                    r_state <= S_LOCKED;
                                end else begin
                                    r_good <= r_good + c_GW'(1);
                                end
                            end else begin
                                r_skip <= 1'b1;
                                r_good <= '0;
                            end
                        end
                        S_LOCKED: begin
                            if (w_inorder) begin
                                r_wrap <= w_wrap;
                            end else begin
                                r_skip  <= 1'b1;
                                r_good  <= '0;
                                r_state <= S_ACQUIRE;
                            end
                        end
                        default: r_state <= S_SEARCH;
                    endcase
                end
            end
        end
    end

    assign o_count       = r_count;
    assign o_count_valid = r_count_valid;
    assign o_illegal     = r_illegal;
    assign o_skip        = r_skip;
    assign o_wrap        = r_wrap;
    assign o_locked      = (r_state == S_LOCKED);
    assign o_err_sticky  = r_err_sticky;
    assign o_err_cnt     = r_err_cnt;

endmodule
`default_nettype wire
